// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with per-entry busy scoreboard; define REGFILE_BYPASS_EN for write-to-read forwarding
module reg_file_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ZERO_REG = 1,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0,
  localparam int unsigned ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rd_addr0,
  output logic [DATA_W-1:0]   rd_data0,
  output logic                rd_busy0,
  input  logic [ADDR_W-1:0]   rd_addr1,
  output logic [DATA_W-1:0]   rd_data1,
  output logic                rd_busy1,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                set_busy_en,
  input  logic [ADDR_W-1:0]   set_busy_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vec
);
  localparam bit ZR = ZERO_REG != 0;
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic zw, zs, z0, z1, f0, f1, s0, s1;
  assign zw = ZR && wr_addr == '0;
  assign zs = ZR && set_busy_addr == '0;
  assign z0 = ZR && rd_addr0 == '0;
  assign z1 = ZR && rd_addr1 == '0;
  // next state: writeback clears busy, issue then sets it, flush clears everything
  always_comb begin
    mem_d = mem_q;
    busy_d = busy_q;
    if (wr_en && !zw) begin
      mem_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    if (set_busy_en && !zs) busy_d[set_busy_addr] = 1'b1;
    if (flush) busy_d = '0;
  end
  // state register with synchronous reset overriding all updates
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: RESET_VALUE};
      busy_q <= '0;
    end else begin
      mem_q <= mem_d;
      busy_q <= busy_d;
    end
  end
`ifdef REGFILE_BYPASS_EN
  assign f0 = wr_en && !zw && wr_addr == rd_addr0;
  assign f1 = wr_en && !zw && wr_addr == rd_addr1;
  assign s0 = set_busy_en && !flush && !zs && set_busy_addr == rd_addr0;
  assign s1 = set_busy_en && !flush && !zs && set_busy_addr == rd_addr1;
`else
  assign f0 = 1'b0;
  assign f1 = 1'b0;
  assign s0 = 1'b0;
  assign s1 = 1'b0;
`endif
  assign rd_data0 = z0 ? '0 : f0 ? wr_data : mem_q[rd_addr0];
  assign rd_data1 = z1 ? '0 : f1 ? wr_data : mem_q[rd_addr1];
  assign rd_busy0 = !z0 && (f0 ? s0 : busy_q[rd_addr0]);
  assign rd_busy1 = !z1 && (f1 ? s1 : busy_q[rd_addr1]);
  assign busy_vec = busy_q;
endmodule
